// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM states, frame geometry and scan-code constants.
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_DATA_BITS  = 8;
  localparam int unsigned PS2_BIT_CNT_W  = $clog2(PS2_DATA_BITS);

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT0  = 8'hE0;
  localparam logic [7:0] PS2_EXT1  = 8'hE1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // PS/2 uses odd parity over the data byte plus the parity bit.
  function automatic logic ps2_parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_frame_rx_if.sv
// Pin and scan-code bundle between the PS/2 pins, the receiver and its consumer.
interface ps2_frame_rx_if;
  import ps2_pkg::*;

  logic                     kbclk;
  logic                     kbdata;
  logic [PS2_DATA_BITS-1:0] data_out;
  logic                     data_valid;
  logic                     frame_err;
  logic                     busy;

  modport slave (
    input  kbclk, kbdata,
    output data_out, data_valid, frame_err, busy
  );

  modport master (
    output kbclk, kbdata,
    input  data_out, data_valid, frame_err, busy
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Synchroniser plus glitch filter for one asynchronous PS/2 pin.
// The output only changes after FILTER_LEN consecutive synced samples disagree with it.
module ps2_line_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Count consecutive disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    filt_d = filt_q;
    cnt_d  = '0;
    if (synced != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: conditions kbclk/kbdata, deserialises 11-bit frames and
// emits either a data_valid strobe with the scan code or a frame_err strobe.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic           clk,
  input  logic           rst_n,
  ps2_frame_rx_if.slave  bus
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PS2_BIT_CNT_W-1:0] LAST_BIT = PS2_BIT_CNT_W'(PS2_DATA_BITS - 1);

  ps2_state_e                 state_q, state_d;
  logic [PS2_BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                       parity_q, parity_d;
  logic [TMO_W-1:0]           tmo_q, tmo_d;
  logic [PS2_DATA_BITS-1:0]   data_out_q, data_out_d;
  logic                       data_valid_q, data_valid_d;
  logic                       frame_err_q, frame_err_d;
  logic                       busy_q, busy_d;
  logic                       kbclk_prev_q, kbclk_prev_d;

  logic kbclk_f, kbdata_f, fall_c;

  ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.kbclk),
    .dout  (kbclk_f)
  );

  ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.kbdata),
    .dout  (kbdata_f)
  );

  assign kbclk_prev_d = kbclk_f;
  assign fall_c       = kbclk_prev_q & ~kbclk_f;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    parity_d     = parity_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    tmo_d        = tmo_q;

    // Stall watchdog: cleared by any fall or while idle, saturates otherwise.
    if (fall_c || (state_q == IDLE)) begin
      tmo_d = '0;
    end else if (tmo_q != '1) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (fall_c && !kbdata_f) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall_c) begin
          shreg_d[bit_cnt_q] = kbdata_f;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + PS2_BIT_CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (fall_c) begin
          parity_d = kbdata_f;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall_c) begin
          state_d = IDLE;
          if (kbdata_f && ps2_parity_ok(shreg_q, parity_q)) begin
            data_out_d   = shreg_q;
            data_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A fall in the expiry cycle keeps the frame alive.
    if ((state_q != IDLE) && !fall_c && (tmo_q == TMO_LAST)) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      parity_q     <= 1'b0;
      tmo_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      kbclk_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      parity_q     <= parity_d;
      tmo_q        <= tmo_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
      kbclk_prev_q <= kbclk_prev_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Bench for ps2_frame_rx: frame-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ps2_frame_rx;
  import ps2_pkg::*;

  localparam int unsigned S = 2;
  localparam int unsigned F = 4;
  localparam int unsigned T = 300;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ps2_frame_rx_if bus();

  ps2_frame_rx #(.SYNC_STAGES(S), .FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int n_busy   = 0;
  int last_lat = -1;

  // Reference model state (values the DUT registers should hold after each edge).
  logic [31:0] hc = '1, hd = '1, wc = '1, wd = '1;
  int          nc = 0, nd = 0;
  logic        m_kc = 1'b1, m_kc_prev = 1'b1, m_kd = 1'b1;
  logic        in_frame = 1'b0;
  logic        bits[$];
  int          idle_cnt = 0;
  logic [7:0]  m_dout = 8'h00;
  logic        m_valid = 1'b0, m_err = 1'b0, m_busy = 1'b0;
  logic        started = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Pin delayed by S edges, then a line only flips once F consecutive delayed samples oppose it.
  task automatic cond_step(input logic [31:0] h, input logic [31:0] w, input int n, input logic f,
                           input logic pin, output logic [31:0] ho, output logic [31:0] wo,
                           output int no, output logic fo);
    logic x, all_opp;
    x  = h[S-1];
    ho = {h[30:0], pin};
    wo = {w[30:0], x};
    no = n + 1;
    fo = f;
    if (no >= int'(F)) begin
      all_opp = 1'b1;
      for (int i = 0; i < int'(F); i++) if (wo[i] == f) all_opp = 1'b0;
      if (all_opp) begin
        fo = ~f;
        no = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    logic       fall, dat, good;
    logic [7:0] byte_v;
    int         ones;
    started = 1'b1;
    if (!rst_n) begin
      hc = '1; hd = '1; wc = '1; wd = '1; nc = 0; nd = 0;
      m_kc = 1'b1; m_kc_prev = 1'b1; m_kd = 1'b1;
      in_frame = 1'b0; bits.delete(); idle_cnt = 0;
      m_dout = 8'h00; m_valid = 1'b0; m_err = 1'b0; m_busy = 1'b0;
    end else begin
      fall    = m_kc_prev && !m_kc;
      dat     = m_kd;
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (fall) begin
        idle_cnt = 0;
        if (!in_frame) begin
          if (!dat) begin
            in_frame = 1'b1;
            bits.delete();
          end
        end else begin
          bits.push_back(dat);
          if (bits.size() == 10) begin
            for (int i = 0; i < 8; i++) byte_v[i] = bits[i];
            ones = $countones(byte_v) + (bits[8] ? 1 : 0);
            good = bits[9] && (ones % 2 == 1);
            if (good) begin
              m_dout  = byte_v;
              m_valid = 1'b1;
            end else begin
              m_err = 1'b1;
            end
            in_frame = 1'b0;
          end
        end
      end else if (in_frame) begin
        idle_cnt++;
        if (idle_cnt == int'(T)) begin
          m_err    = 1'b1;
          in_frame = 1'b0;
        end
      end
      m_busy    = in_frame;
      m_kc_prev = m_kc;
      cond_step(hc, wc, nc, m_kc, bus.kbclk, hc, wc, nc, m_kc);
      cond_step(hd, wd, nd, m_kd, bus.kbdata, hd, wd, nd, m_kd);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("data_out",   32'(bus.data_out),   32'(m_dout));
      chk("data_valid", 32'(bus.data_valid), 32'(m_valid));
      chk("frame_err",  32'(bus.frame_err),  32'(m_err));
      chk("busy",       32'(bus.busy),       32'(m_busy));
      if (bus.data_valid && bus.frame_err) chk("valid_err_exclusive", 32'd1, 32'd0);
      if (bus.data_valid === 1'b1) n_valid++;
      if (bus.frame_err === 1'b1)  n_err++;
      if (bus.busy === 1'b1)       n_busy++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives the first nbits of a frame; glitch_bit gets an F-1 cycle low spike on kbclk.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                            input int half, input int glitch_bit, input int nbits);
    logic fb [11];
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[i+1] = b[i];
    fb[9]  = ~(^b) ^ bad_par;
    fb[10] = stop;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.kbdata = fb[i];
      if (i == glitch_bit) begin
        wait_cyc(half / 2);
        bus.kbclk = 1'b0;
        wait_cyc(int'(F) - 1);
        bus.kbclk = 1'b1;
        wait_cyc(half - half / 2 - (int'(F) - 1));
      end else begin
        wait_cyc(half);
      end
      bus.kbclk = 1'b0;
      if (i == 10) begin
        last_lat = -1;
        for (int k = 1; k <= half; k++) begin
          @(posedge clk);
          #1;
          if (last_lat < 0 && (bus.data_valid || bus.frame_err)) last_lat = k;
        end
        @(negedge clk);
      end else begin
        wait_cyc(half);
      end
      bus.kbclk = 1'b1;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0, b0;
    bus.kbclk  = 1'b1;
    bus.kbdata = 1'b1;
    rst_n      = 1'b0;
    wait_cyc(3);
    chk("rst_data_out", 32'(bus.data_out), 32'h00);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_valid",    32'(bus.data_valid), 32'd0);
    chk("rst_err",      32'(bus.frame_err),  32'd0);
    rst_n = 1'b1;
    wait_cyc(5);

    // Good frame 0x1C, plus pin-to-strobe latency.
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1C, 1'b0, 1'b1, 12, -1, 11);
    wait_cyc(20);
    chk("t1_valid_cnt", 32'(n_valid - v0), 32'd1);
    chk("t1_err_cnt",   32'(n_err - e0),   32'd0);
    chk("t1_data_out",  32'(bus.data_out), 32'h1C);
    chk("t1_latency",   32'(last_lat),     32'd7);

    // Wrong parity.
    v0 = n_valid; e0 = n_err;
    send_frame(PS2_BREAK, 1'b1, 1'b1, 12, -1, 11);
    wait_cyc(20);
    chk("t2_valid_cnt", 32'(n_valid - v0), 32'd0);
    chk("t2_err_cnt",   32'(n_err - e0),   32'd1);
    chk("t2_data_out",  32'(bus.data_out), 32'h1C);
    chk("t2_latency",   32'(last_lat),     32'd7);

    // Bad stop bit.
    v0 = n_valid; e0 = n_err;
    send_frame(8'h12, 1'b0, 1'b0, 12, -1, 11);
    wait_cyc(20);
    chk("t3_valid_cnt", 32'(n_valid - v0), 32'd0);
    chk("t3_err_cnt",   32'(n_err - e0),   32'd1);
    chk("t3_data_out",  32'(bus.data_out), 32'h1C);

    // Sub-threshold kbclk glitch in the middle of data bit 3.
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1C, 1'b0, 1'b1, 12, 4, 11);
    wait_cyc(20);
    chk("t4_valid_cnt", 32'(n_valid - v0), 32'd1);
    chk("t4_err_cnt",   32'(n_err - e0),   32'd0);
    chk("t4_data_out",  32'(bus.data_out), 32'h1C);

    // Abort after 5 data bits, then stall past the timeout.
    v0 = n_valid; e0 = n_err;
    send_frame(8'hA5, 1'b0, 1'b1, 12, -1, 6);
    wait_cyc(int'(T) + 10);
    chk("t5_err_cnt",   32'(n_err - e0),   32'd1);
    chk("t5_valid_cnt", 32'(n_valid - v0), 32'd0);
    chk("t5_busy",      32'(bus.busy),     32'd0);
    send_frame(PS2_EXT0, 1'b0, 1'b1, 12, -1, 11);
    wait_cyc(20);
    chk("t5_data_out",  32'(bus.data_out), 32'hE0);

    // Reset mid-frame after bit 3.
    send_frame(8'h5A, 1'b0, 1'b1, 12, -1, 4);
    @(negedge clk);
    rst_n = 1'b0;
    wait_cyc(2);
    chk("t6_rst_data_out", 32'(bus.data_out),   32'h00);
    chk("t6_rst_valid",    32'(bus.data_valid), 32'd0);
    chk("t6_rst_err",      32'(bus.frame_err),  32'd0);
    chk("t6_rst_busy",     32'(bus.busy),       32'd0);
    rst_n = 1'b1;
    wait_cyc(5);
    send_frame(8'h77, 1'b0, 1'b1, 12, -1, 11);
    wait_cyc(20);
    chk("t6_data_out", 32'(bus.data_out), 32'h77);

    // Falling kbclk with kbdata high in idle is ignored.
    v0 = n_valid; e0 = n_err; b0 = n_busy;
    @(negedge clk);
    bus.kbdata = 1'b1;
    wait_cyc(12);
    bus.kbclk = 1'b0;
    wait_cyc(12);
    bus.kbclk = 1'b1;
    wait_cyc(20);
    chk("t6_idle_busy",  32'(n_busy - b0),  32'd0);
    chk("t6_idle_valid", 32'(n_valid - v0), 32'd0);
    chk("t6_idle_err",   32'(n_err - e0),   32'd0);

    // Randomised frames, errors, glitches, aborts and near-timeout stalls.
    for (int it = 0; it < 40; it++) begin
      int mode, half;
      logic [7:0] b;
      mode = int'($urandom_range(0, 9));
      half = int'($urandom_range(8, 20));
      b    = 8'($urandom_range(0, 255));
      case (mode)
        5: send_frame(b, 1'b1, 1'b1, half, -1, 11);
        6: send_frame(b, 1'b0, 1'b0, half, -1, 11);
        7: send_frame(b, 1'b0, 1'b1, half, int'($urandom_range(0, 10)), 11);
        8: begin
          send_frame(b, 1'b0, 1'b1, half, -1, int'($urandom_range(1, 10)));
          wait_cyc(int'(T) + int'($urandom_range(0, 20)));
        end
        9: begin
          send_frame(b, 1'b0, 1'b1, half, -1, int'($urandom_range(1, 10)));
          wait_cyc(int'(T) - half - 6 + int'($urandom_range(0, 12)));
        end
        default: send_frame(b, 1'b0, 1'b1, half, -1, 11);
      endcase
      if (mode != 9) wait_cyc(int'($urandom_range(5, 30)));
    end
    wait_cyc(int'(T) + 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
